count_capture: RTL and testbench

Timestamp capture stage that sits directly downstream of the free-running `counter` and consumes its `count` output. On each `trigger` it records the current count, extended with a wrap-epoch field, into a small first-word-fall-through FIFO. The FIFO is drained through a valid/ready handshake. The block detects counter wrap-around so that timestamps remain monotonic across wraps. It also reports full and dropped-sample conditions to the bench.

---
 rtl/count_capture.sv | 122 ++++++++++++
 tb/tb_count_capture.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_capture.sv
// Purpose : timestamp capture; on trigger, pushes {epoch, count} into a small FWFT FIFO.
// Latency : a stamp triggered at edge N is at the FIFO head after edge N (no same-cycle bypass).
// Backpr. : drained via valid/ready; a trigger into a full FIFO without a same-cycle pop
//           is dropped and latches the sticky dropped flag.
//
// Ports:
//   clock, reset  rising-edge clock, async active-high reset
//   count         upstream free-running counter value (Size bits)
//   trigger       capture request for the current stamp
//   data/valid    head-of-FIFO stamp {epoch, count} and its valid flag
//   ready         consumer accepts data this cycle
//   full          FIFO holds Depth entries
//   dropped       sticky: a trigger was lost to a full FIFO
//   wrap          one-cycle pulse after the edge that saw count go all-ones -> 0
module count_capture #(
   parameter int Size     = 5,
   parameter int WrapBits = 3,
   parameter int Depth    = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [Size-1:0]          count,
   input  logic                     trigger,
   output logic [WrapBits+Size-1:0] data,
   output logic                     valid,
   input  logic                     ready,
   output logic                     full,
   output logic                     dropped,
   output logic                     wrap
);

   localparam int Width = WrapBits + Size;
   localparam int AW    = $clog2(Depth);
   localparam logic [AW:0] FullOcc = (AW+1)'(Depth);

   // ---------------------------------------------------------------
   // Wrap detection and epoch tracking
   // ---------------------------------------------------------------
   logic [Size-1:0]     prev_count;
   logic                prev_valid;
   logic [WrapBits-1:0] epoch;
   logic                wrap_now;
   logic [WrapBits-1:0] epoch_now;
   logic [Width-1:0]    stamp;

   // prev_valid keeps the first edge after reset from seeing a bogus
   // all-ones -> 0 transition against the reset value of prev_count.
   assign wrap_now  = prev_valid && (prev_count == '1) && (count == '0);
   assign epoch_now = epoch + WrapBits'(wrap_now);
   // A trigger on the wrap edge must already carry the new epoch.
   assign stamp     = {epoch_now, count};

   // ---------------------------------------------------------------
   // FIFO state
   // ---------------------------------------------------------------
   logic [Width-1:0] mem [Depth];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      occ;
   logic [Width-1:0] last_popped;
   logic             push;
   logic             pop;
   logic             drop;

   assign valid = (occ != '0);
   assign full  = (occ == FullOcc);
   assign pop   = valid && ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push  = trigger && (!full || pop);
   assign drop  = trigger && full && !pop;

   // When empty, present the last value handed out (0 after reset) rather
   // than whatever stale word the read pointer happens to address.
   assign data = valid ? mem[rd_ptr] : last_popped;

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= stamp;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         last_popped <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr      <= rd_ptr + 1'b1;
            last_popped <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_count <= '0;
         prev_valid <= 1'b0;
         epoch      <= '0;
         wrap       <= 1'b0;
         dropped    <= 1'b0;
      end else begin
         prev_count <= count;
         prev_valid <= 1'b1;
         epoch      <= epoch_now;
         wrap       <= wrap_now;
         if (drop) begin
            dropped <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_count_capture.sv
// Bench for count_capture: vector table for the basic capture/wrap path,
// then hand sequences for full/drop, push+pop at full, epoch rollover and
// mid-drain reset, all backed by a scoreboard queue of expected stamps.
module tb_count_capture;

   localparam int Size     = 5;
   localparam int WrapBits = 3;
   localparam int Depth    = 4;

   logic       clock   = 1'b0;
   logic       reset   = 1'b0;
   logic       trigger = 1'b0;
   logic       ready   = 1'b0;
   logic [4:0] count   = '0;
   logic [7:0] data;
   logic       valid;
   logic       full;
   logic       dropped;
   logic       wrap;

   count_capture #(.Size(Size), .WrapBits(WrapBits), .Depth(Depth)) dut (
      .clock   (clock),
      .reset   (reset),
      .count   (count),
      .trigger (trigger),
      .data    (data),
      .valid   (valid),
      .ready   (ready),
      .full    (full),
      .dropped (dropped),
      .wrap    (wrap)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   int dut_wraps = 0;

   // Scoreboard and reference state
   logic [7:0] sb [$];
   logic [2:0] m_epoch;
   logic [4:0] m_prev;
   logic       m_prev_valid;
   logic       m_dropped;
   logic       m_wrap;

   typedef struct {
      logic [4:0] cnt;
      logic       trig;
      logic       rdy;
      logic       e_valid;
      logic       e_full;
      logic       e_dropped;
      logic       e_wrap;
      logic [7:0] e_data;
   } vec_t;

   vec_t       vecs [8];
   logic [7:0] exp_drain [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_epoch      = '0;
      m_prev       = '0;
      m_prev_valid = 1'b0;
      m_dropped    = 1'b0;
      m_wrap       = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"},   valid,   0);
      chk({tag, "_full"},    full,    0);
      chk({tag, "_dropped"}, dropped, 0);
      chk({tag, "_wrap"},    wrap,    0);
      chk({tag, "_data"},    data,    0);
   endtask

   // Called ~1 time unit after an edge: asserts reset, checks outputs
   // with no clock edge in between, holds two edges, then releases.
   task automatic do_reset(input string tag);
      reset   = 1'b1;
      trigger = 1'b0;
      ready   = 1'b0;
      count   = '0;
      #1;
      check_reset_outputs(tag);
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // One clock with the currently driven inputs; scoreboard predicts the
   // effect of the edge and the outputs are compared just after it.
   task automatic tick();
      int         occ_pre;
      logic       pop_m;
      logic       push_m;
      logic       wrap_m;
      logic [2:0] ep;
      logic [7:0] exp_d;
      occ_pre = sb.size();
      pop_m   = (occ_pre > 0) && ready;
      if (pop_m) begin
         exp_d = sb.pop_front();
         chk("pop_data", data, exp_d);
      end
      wrap_m = m_prev_valid && (m_prev == 5'd31) && (count == 5'd0);
      ep     = m_epoch + {2'b00, wrap_m};
      push_m = trigger && ((occ_pre < Depth) || pop_m);
      if (trigger && !push_m) m_dropped = 1'b1;
      if (push_m) sb.push_back({ep, count});
      m_epoch      = ep;
      m_prev       = count;
      m_prev_valid = 1'b1;
      m_wrap       = wrap_m;
      @(posedge clock);
      #1;
      if (wrap) dut_wraps++;
      chk("sb_valid",   valid,   (sb.size() > 0));
      chk("sb_full",    full,    (sb.size() == Depth));
      chk("sb_dropped", dropped, m_dropped);
      chk("sb_wrap",    wrap,    m_wrap);
      if (sb.size() > 0) chk("sb_head", data, sb[0]);
   endtask

   task automatic step(input int c, input logic t, input logic r);
      count   = 5'(c);
      trigger = t;
      ready   = r;
      tick();
   endtask

   initial begin
      // cnt trig rdy | valid full dropped wrap data
      vecs[0] = '{5'd7,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07};
      vecs[1] = '{5'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[2] = '{5'd30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[3] = '{5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[4] = '{5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20};
      vecs[5] = '{5'd1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h21};
      vecs[6] = '{5'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[7] = '{5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

      #2;
      do_reset("rst0");

      // Basic capture, pop, wrap into epoch 1
      for (int i = 0; i < 8; i++) begin
         step(int'(vecs[i].cnt), vecs[i].trig, vecs[i].rdy);
         chk($sformatf("vec%0d_valid", i),   valid,   vecs[i].e_valid);
         chk($sformatf("vec%0d_full", i),    full,    vecs[i].e_full);
         chk($sformatf("vec%0d_dropped", i), dropped, vecs[i].e_dropped);
         chk($sformatf("vec%0d_wrap", i),    wrap,    vecs[i].e_wrap);
         if (vecs[i].e_valid) chk($sformatf("vec%0d_data", i), data, vecs[i].e_data);
      end

      // Fill, drop, drain in order
      do_reset("rst1");
      for (int c = 3; c <= 6; c++) step(c, 1'b1, 1'b0);
      chk("fill_full", full, 1);
      chk("fill_nodrop", dropped, 0);
      step(7, 1'b1, 1'b0);
      chk("drop_flag", dropped, 1);
      chk("drop_full", full, 1);
      exp_drain = '{8'h03, 8'h04, 8'h05, 8'h06};
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain_%0d", i), data, exp_drain[i]);
         step(8 + i, 1'b0, 1'b1);
      end
      chk("drain_empty", valid, 0);
      chk("drain_sticky", dropped, 1);

      // Push and pop together while full
      do_reset("rst2");
      for (int c = 10; c <= 13; c++) step(c, 1'b1, 1'b0);
      step(14, 1'b1, 1'b1);
      chk("pp_full", full, 1);
      chk("pp_nodrop", dropped, 0);
      exp_drain = '{8'h0b, 8'h0c, 8'h0d, 8'h0e};
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("pp_drain_%0d", i), data, exp_drain[i]);
         step(15 + i, 1'b0, 1'b1);
      end
      chk("pp_empty", valid, 0);

      // Eight wraps roll the epoch back to 0
      do_reset("rst3");
      dut_wraps = 0;
      for (int k = 1; k <= 256; k++) step(k % 32, 1'b0, 1'b0);
      step(1, 1'b0, 1'b0);
      step(2, 1'b1, 1'b0);
      chk("roll_valid", valid, 1);
      chk("roll_data", data, 8'h02);
      chk("roll_wraps", dut_wraps, 8);

      // Reset mid-drain with 3 entries queued and dropped set
      do_reset("rst4");
      for (int c = 20; c <= 23; c++) step(c, 1'b1, 1'b0);
      step(24, 1'b1, 1'b0);
      step(31, 1'b0, 1'b1);
      chk("pre_rst_valid", valid, 1);
      chk("pre_rst_dropped", dropped, 1);
      reset   = 1'b1;
      trigger = 1'b1;
      ready   = 1'b1;
      count   = 5'd0;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_trig_ignored", valid, 0);
      trigger = 1'b0;
      reset   = 1'b0;
      step(0, 1'b0, 1'b0);
      chk("rst_nowrap", wrap, 0);
      step(1, 1'b1, 1'b0);
      chk("post_rst_data", data, 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
